// File: rtl/dht_pkg.sv
// -----------------------------------------------------------------------------
// dht_pkg
// Shared definitions for the DHT measurement sequencer:
//   - dht_state_t   : sequencer state encoding
//   - DHT_FRAME_W   : received frame width (5 bytes)
//   - DHT_IDX_*     : byte positions inside the frame (byte 4 is the MSB byte)
//   - dht_byte()    : extract one frame byte by index
//   - dht_csum_ok() : frame checksum verification
// -----------------------------------------------------------------------------
package dht_pkg;

    localparam int DHT_FRAME_W = 40;

    // Byte positions in {H_i, H_d, T_i, T_d, csum}
    localparam int DHT_IDX_H_INT = 4;
    localparam int DHT_IDX_H_DEC = 3;
    localparam int DHT_IDX_T_INT = 2;
    localparam int DHT_IDX_T_DEC = 1;
    localparam int DHT_IDX_CSUM  = 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CHECK   = 3'd3,
        ST_HOLDOFF = 3'd4
    } dht_state_t;

    function automatic logic [7:0] dht_byte(input logic [DHT_FRAME_W-1:0] frame, input int idx);
        return frame[idx*8 +: 8];
    endfunction

    // Sum of the four data bytes is kept in 10 bits; only the low byte is
    // compared against the transmitted checksum (mod-256 arithmetic).
    function automatic logic dht_csum_ok(input logic [DHT_FRAME_W-1:0] frame);
        logic [9:0] sum_s;
        sum_s = {2'b00, dht_byte(frame, DHT_IDX_H_INT)}
              + {2'b00, dht_byte(frame, DHT_IDX_H_DEC)}
              + {2'b00, dht_byte(frame, DHT_IDX_T_INT)}
              + {2'b00, dht_byte(frame, DHT_IDX_T_DEC)};
        return (sum_s[7:0] == dht_byte(frame, DHT_IDX_CSUM));
    endfunction

endpackage

// File: rtl/dht_ms_tick.sv
// -----------------------------------------------------------------------------
// dht_ms_tick
// Free-running prescaler producing a one-cycle pulse every millisecond
// (every CLK_HZ/1000 clock cycles). Shared by all ms-based counters.
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous active-high reset
//   tick out one-cycle ms pulse (registered)
// -----------------------------------------------------------------------------
module dht_ms_tick #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int DIV = CLK_HZ / 1000;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Prescaler counter; wraps and emits the tick on its last count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= {CW{1'b0}};
            tick_r <= 1'b0;
        end else if (cnt_r == LAST) begin
            cnt_r  <= {CW{1'b0}};
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + CW'(1);
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/dht_meas_ctrl.sv
// -----------------------------------------------------------------------------
// dht_meas_ctrl
// Measurement sequencer for the DHT sensor path: launches bus transactions on
// request, enforces the minimum inter-transaction interval, supervises the
// driver with a watchdog, verifies the frame checksum and retries failures.
// Optional feature macro: DHT_AUTO_POLL_EN (periodic polling while auto_en=1).
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   button                one-cycle measurement request
//   auto_en               periodic polling enable (unused without macro)
//   drv_start             one-cycle pulse launching a bus transaction
//   drv_done / drv_fail   driver completion / protocol error pulses
//   drv_data              received 40-bit frame
//   hum_o / temp_o        last good humidity / temperature words
//   valid                 at least one good reading since reset
//   error                 last sequence failed after all retries
//   busy                  sequencer not idle
//   retry_cnt             retries used by the current or last sequence
// -----------------------------------------------------------------------------
module dht_meas_ctrl
    import dht_pkg::*;
#(
    parameter int CLK_HZ          = 100_000_000,
    parameter int MIN_INTERVAL_MS = 2000,
    parameter int TIMEOUT_MS      = 50,
    parameter int MAX_RETRIES     = 3,
    parameter int AUTO_PERIOD_MS  = 5000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   button,
    input  logic                   auto_en,
    output logic                   drv_start,
    input  logic                   drv_done,
    input  logic                   drv_fail,
    input  logic [DHT_FRAME_W-1:0] drv_data,
    output logic [15:0]            hum_o,
    output logic [15:0]            temp_o,
    output logic                   valid,
    output logic                   error,
    output logic                   busy,
    output logic [1:0]             retry_cnt
);
    localparam int HO_W = $clog2(MIN_INTERVAL_MS + 1);
    localparam int WD_W = $clog2(TIMEOUT_MS + 1);
    localparam logic [HO_W-1:0] HO_LOAD   = HO_W'(MIN_INTERVAL_MS);
    localparam logic [WD_W-1:0] WD_LIMIT  = WD_W'(TIMEOUT_MS);
    localparam logic [1:0]      RETRY_MAX = 2'(MAX_RETRIES);

    dht_state_t             state_r;
    logic                   pend_r;
    logic                   retry_pend_r;
    logic [HO_W-1:0]        holdoff_r;
    logic [WD_W-1:0]        wdog_r;
    logic [DHT_FRAME_W-1:0] frame_r;
    logic [15:0]            hum_r;
    logic [15:0]            temp_r;
    logic                   valid_r;
    logic                   error_r;
    logic                   busy_r;
    logic [1:0]             retry_cnt_r;
    logic                   drv_start_r;

    logic tick_s;
    logic auto_req_s;
    logic req_s;
    logic fail_s;

    dht_ms_tick #(.CLK_HZ(CLK_HZ)) u_ms_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

`ifdef DHT_AUTO_POLL_EN
    localparam int AP_W = $clog2(AUTO_PERIOD_MS + 1);
    localparam logic [AP_W-1:0] AP_LAST = AP_W'(AUTO_PERIOD_MS - 1);

    logic [AP_W-1:0] auto_cnt_r;
    logic            auto_en_q_r;
    logic            auto_req_r;

    // Auto-poll period counter; restarts on a rising auto_en
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            auto_cnt_r  <= {AP_W{1'b0}};
            auto_en_q_r <= 1'b0;
            auto_req_r  <= 1'b0;
        end else begin
            auto_en_q_r <= auto_en;
            auto_req_r  <= 1'b0;
            if (auto_en && !auto_en_q_r) begin
                auto_cnt_r <= {AP_W{1'b0}};
            end else if (auto_en && tick_s) begin
                if (auto_cnt_r == AP_LAST) begin
                    auto_cnt_r <= {AP_W{1'b0}};
                    auto_req_r <= 1'b1;
                end else begin
                    auto_cnt_r <= auto_cnt_r + AP_W'(1);
                end
            end else begin
                auto_cnt_r <= auto_cnt_r;
            end
        end
    end

    assign auto_req_s = auto_req_r;
`else
    logic unused_auto_en_s;
    assign unused_auto_en_s = auto_en;
    assign auto_req_s       = 1'b0;
`endif

    assign req_s = button | auto_req_s;

    // Attempt failure: driver error or watchdog in WAIT (fail beats done), bad checksum in CHECK
    always_comb begin
        fail_s = 1'b0;
        if (state_r == ST_WAIT) begin
            fail_s = drv_fail || (wdog_r == WD_LIMIT);
        end else if (state_r == ST_CHECK) begin
            fail_s = !dht_csum_ok(frame_r);
        end else begin
            fail_s = 1'b0;
        end
    end

    // One-deep request latch; requests during a pending retry fold into that retry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_r <= 1'b0;
        end else if (req_s && !retry_pend_r) begin
            pend_r <= 1'b1;
        end else if (state_r == ST_LAUNCH && !retry_pend_r) begin
            pend_r <= 1'b0;
        end else begin
            pend_r <= pend_r;
        end
    end

    // Holdoff counter: reloads on every launch, counts down on ms ticks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            holdoff_r <= {HO_W{1'b0}};
        end else if (state_r == ST_LAUNCH) begin
            holdoff_r <= HO_LOAD;
        end else if (tick_s && (holdoff_r != {HO_W{1'b0}})) begin
            holdoff_r <= holdoff_r - HO_W'(1);
        end else begin
            holdoff_r <= holdoff_r;
        end
    end

    // Watchdog: cleared at launch, counts ms ticks while waiting, saturates at the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_r <= {WD_W{1'b0}};
        end else if (state_r == ST_LAUNCH) begin
            wdog_r <= {WD_W{1'b0}};
        end else if ((state_r == ST_WAIT) && tick_s && (wdog_r != WD_LIMIT)) begin
            wdog_r <= wdog_r + WD_W'(1);
        end else begin
            wdog_r <= wdog_r;
        end
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            retry_pend_r <= 1'b0;
            frame_r      <= {DHT_FRAME_W{1'b0}};
            hum_r        <= 16'h0000;
            temp_r       <= 16'h0000;
            valid_r      <= 1'b0;
            error_r      <= 1'b0;
            busy_r       <= 1'b0;
            retry_cnt_r  <= 2'd0;
            drv_start_r  <= 1'b0;
        end else begin
            drv_start_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if ((pend_r || retry_pend_r) && (holdoff_r == {HO_W{1'b0}})) begin
                        state_r     <= ST_LAUNCH;
                        drv_start_r <= 1'b1;
                        busy_r      <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_LAUNCH: begin
                    state_r      <= ST_WAIT;
                    retry_pend_r <= 1'b0;
                    if (!retry_pend_r) begin
                        retry_cnt_r <= 2'd0;
                    end else begin
                        retry_cnt_r <= retry_cnt_r;
                    end
                end
                ST_WAIT: begin
                    if (!fail_s && drv_done) begin
                        frame_r <= drv_data;
                        state_r <= ST_CHECK;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_CHECK: begin
                    if (!fail_s) begin
                        hum_r   <= {dht_byte(frame_r, DHT_IDX_H_INT), dht_byte(frame_r, DHT_IDX_H_DEC)};
                        temp_r  <= {dht_byte(frame_r, DHT_IDX_T_INT), dht_byte(frame_r, DHT_IDX_T_DEC)};
                        valid_r <= 1'b1;
                        error_r <= 1'b0;
                        state_r <= ST_HOLDOFF;
                    end else begin
                        state_r <= ST_CHECK;
                    end
                end
                ST_HOLDOFF: begin
                    if (holdoff_r == {HO_W{1'b0}}) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_HOLDOFF;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase

            // Failure handling overrides the WAIT/CHECK hold paths above
            if (fail_s) begin
                state_r <= ST_HOLDOFF;
                if (retry_cnt_r < RETRY_MAX) begin
                    retry_cnt_r  <= retry_cnt_r + 2'd1;
                    retry_pend_r <= 1'b1;
                end else begin
                    error_r      <= 1'b1;
                    retry_pend_r <= 1'b0;
                end
            end
        end
    end

    assign drv_start = drv_start_r;
    assign hum_o     = hum_r;
    assign temp_o    = temp_r;
    assign valid     = valid_r;
    assign error     = error_r;
    assign busy      = busy_r;
    assign retry_cnt = retry_cnt_r;

endmodule
